rmii_rx: RTL and testbench



---
 rtl/rmii_rx_if.sv | 17 +
 rtl/rmii_rx.sv | 212 +++++++++++++++++++++
 tb/tb_rmii_rx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_rx_if.sv
// rmii_rx_if: byte stream from the RMII receive front end to the frame parser.
//   received_byte  assembled byte, meaningful only while byte_valid
//   byte_valid     one-cycle strobe per byte (SFD 0xD5 first, then DA..FCS)
//   frame_active   high from the SFD strobe until the frame_end strobe
//   frame_end      one-cycle strobe at frame termination
//   frame_error    qualified by frame_end: partial byte, RXER or oversize
// master = rmii_rx (producer), slave = consumer.
interface rmii_rx_if;
    logic [7:0] received_byte;
    logic       byte_valid;
    logic       frame_active;
    logic       frame_end;
    logic       frame_error;

    modport master (output received_byte, byte_valid, frame_active, frame_end, frame_error);
    modport slave  (input  received_byte, byte_valid, frame_active, frame_end, frame_error);
endinterface

// File: rtl/rmii_rx.sv
// rmii_rx: RMII receive front end (LAN8720 pins -> byte stream).
// Registers the PHY pins on the 50 MHz reference clock, aligns on the SFD,
// assembles LSB-first dibits into bytes, filters CRS_DV end-of-frame toggling
// and reports frame end with partial-byte / RXER / oversize errors.
//
// Ports:
//   clk          50 MHz RMII reference clock
//   resetn       asynchronous active-low reset
//   rmii_crs_dv  PHY CRS_DV
//   rmii_rxd     PHY RXD[1:0]
//   rmii_rx_er   PHY RXER
//   rx           byte stream output (rmii_rx_if.master)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE     | carrier absent, waiting for CRS_DV
// S_PREAMBLE | counting 01 dibits, waiting for the 11 SFD dibit
// S_DATA     | assembling frame bytes after the SFD
// S_DROP     | rejected or aborted frame, waiting for carrier to go idle
module rmii_rx #(
    parameter int PREAMBLE_MIN_DIBITS = 8,
    parameter int MAX_FRAME_BYTES     = 1522
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rmii_crs_dv,
    input  logic [1:0] rmii_rxd,
    input  logic       rmii_rx_er,
    rmii_rx_if.master  rx
);

    localparam int              CNT_W    = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] BYTE_MAX = CNT_W'(MAX_FRAME_BYTES);
    localparam logic [7:0]      PRE_MIN  = 8'(PREAMBLE_MIN_DIBITS);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t state, state_nxt;

    logic             crs_dv_q, rx_er_q;
    logic [1:0]       rxd_q;
    logic             hold_valid, hold_crs, hold_er;
    logic [1:0]       hold_dibit;

    logic [7:0]       shreg, shreg_nxt;
    logic [1:0]       dibit_idx, dibit_idx_nxt;
    logic [7:0]       pre_cnt, pre_cnt_nxt;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic             sticky_err, sticky_err_nxt;

    logic [7:0]       rb_q, rb_nxt;
    logic             bv_q, bv_nxt, fa_q, fa_nxt, fe_q, fe_nxt, ferr_q, ferr_nxt;

    logic [7:0]       shifted;
    logic             crs_low2;
    logic             commit;

    assign rx.received_byte = rb_q;
    assign rx.byte_valid    = bv_q;
    assign rx.frame_active  = fa_q;
    assign rx.frame_end     = fe_q;
    assign rx.frame_error   = ferr_q;

    // Held dibit enters at the top; after four commits bits 1:0 hold the first.
    assign shifted  = {hold_dibit, shreg[7:2]};
    // The held sample and the current sample are consecutive CRS_DV samples.
    assign crs_low2 = !hold_crs && !crs_dv_q;
    // A low CRS_DV on the first dibit of a nibble is the RMII toggle when
    // carrier returns on the very next sample; the data is still valid.
    assign commit   = hold_crs || (!dibit_idx[0] && crs_dv_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crs_dv_q   <= 1'b0;
            rxd_q      <= 2'b00;
            rx_er_q    <= 1'b0;
            hold_valid <= 1'b0;
            hold_crs   <= 1'b0;
            hold_dibit <= 2'b00;
            hold_er    <= 1'b0;
            shreg      <= 8'h00;
            dibit_idx  <= 2'd0;
            pre_cnt    <= 8'd0;
            byte_cnt   <= '0;
            sticky_err <= 1'b0;
            rb_q       <= 8'h00;
            bv_q       <= 1'b0;
            fa_q       <= 1'b0;
            fe_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            crs_dv_q   <= rmii_crs_dv;
            rxd_q      <= rmii_rxd;
            rx_er_q    <= rmii_rx_er;
            hold_valid <= 1'b1;
            hold_crs   <= crs_dv_q;
            hold_dibit <= rxd_q;
            hold_er    <= rx_er_q;
            shreg      <= shreg_nxt;
            dibit_idx  <= dibit_idx_nxt;
            pre_cnt    <= pre_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            sticky_err <= sticky_err_nxt;
            rb_q       <= rb_nxt;
            bv_q       <= bv_nxt;
            fa_q       <= fa_nxt;
            fe_q       <= fe_nxt;
            ferr_q     <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        dibit_idx_nxt  = dibit_idx;
        pre_cnt_nxt    = pre_cnt;
        byte_cnt_nxt   = byte_cnt;
        sticky_err_nxt = sticky_err;
        rb_nxt         = rb_q;
        bv_nxt         = 1'b0;
        fa_nxt         = fa_q;
        fe_nxt         = 1'b0;
        ferr_nxt       = 1'b0;

        unique case (state)
            S_IDLE: begin
                pre_cnt_nxt = 8'd0;
                if (crs_dv_q) begin
                    state_nxt = S_PREAMBLE;
                end
            end

            S_PREAMBLE: begin
                if (crs_low2) begin
                    state_nxt = S_IDLE;
                end else if (hold_valid) begin
                    unique case (hold_dibit)
                        2'b00: ;
                        2'b01: begin
                            shreg_nxt = shifted;
                            if (pre_cnt != 8'hFF) begin
                                pre_cnt_nxt = pre_cnt + 8'd1;
                            end
                        end
                        2'b11: begin
                            shreg_nxt = shifted;
                            if (pre_cnt >= PRE_MIN) begin
                                rb_nxt         = shifted;
                                bv_nxt         = 1'b1;
                                fa_nxt         = 1'b1;
                                dibit_idx_nxt  = 2'd0;
                                byte_cnt_nxt   = '0;
                                sticky_err_nxt = 1'b0;
                                state_nxt      = S_DATA;
                            end else begin
                                state_nxt = S_DROP;
                            end
                        end
                        default: state_nxt = S_DROP;
                    endcase
                end
            end

            S_DATA: begin
                if (hold_valid) begin
                    if (commit) begin
                        shreg_nxt     = shifted;
                        dibit_idx_nxt = dibit_idx + 2'd1;
                        if (hold_er) begin
                            sticky_err_nxt = 1'b1;
                        end
                        if (dibit_idx == 2'd3) begin
                            if (byte_cnt == BYTE_MAX) begin
                                // One byte too many: abort instead of emitting it.
                                fe_nxt    = 1'b1;
                                ferr_nxt  = 1'b1;
                                fa_nxt    = 1'b0;
                                state_nxt = S_DROP;
                            end else begin
                                rb_nxt       = shifted;
                                bv_nxt       = 1'b1;
                                byte_cnt_nxt = byte_cnt + 1'b1;
                            end
                        end
                    end else begin
                        fe_nxt    = 1'b1;
                        ferr_nxt  = sticky_err || (dibit_idx != 2'd0);
                        fa_nxt    = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                if (crs_low2) begin
                    state_nxt = S_IDLE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rmii_rx.sv
// tb_rmii_rx: drives RMII dibit streams into two rmii_rx instances (default
// size limit and a 64-byte limit) and compares the emitted byte stream,
// per-byte latency and frame termination against a frame-level model.
module tb_rmii_rx;

    localparam int BIG_MAX   = 1522;
    localparam int SMALL_MAX = 64;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       crs_dv = 1'b0;
    logic       rx_er  = 1'b0;
    logic [1:0] rxd    = 2'b00;

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rmii_rx_if rx0 ();
    rmii_rx_if rx1 ();

    rmii_rx #(.PREAMBLE_MIN_DIBITS(8), .MAX_FRAME_BYTES(BIG_MAX)) u_dut_big (
        .clk        (clk),
        .resetn     (resetn),
        .rmii_crs_dv(crs_dv),
        .rmii_rxd   (rxd),
        .rmii_rx_er (rx_er),
        .rx         (rx0)
    );

    rmii_rx #(.PREAMBLE_MIN_DIBITS(8), .MAX_FRAME_BYTES(SMALL_MAX)) u_dut_small (
        .clk        (clk),
        .resetn     (resetn),
        .rmii_crs_dv(crs_dv),
        .rmii_rxd   (rxd),
        .rmii_rx_er (rx_er),
        .rx         (rx1)
    );

    typedef struct {
        logic [1:0] d;
        logic       crs;
        logic       er;
        logic       mark;
    } dib_t;

    typedef struct {
        logic [7:0]  b;
        int unsigned c;
    } ev_t;

    // Stimulus and model: dibits to drive, bytes the frame carries (SFD first),
    // drive cycle of the last dibit of each carried byte.
    dib_t        dq[$];
    logic [7:0]  fb[$];
    int unsigned mk[$];

    // Observations, appended only by the monitor.
    ev_t  gb0[$], gb1[$];
    logic ge0[$], ge1[$];
    int   viol0 = 0, viol1 = 0;

    int rd[2], re[2], vb[2];
    int checks = 0, errors = 0;

    always @(negedge clk) begin
        if (rx0.byte_valid) gb0.push_back('{rx0.received_byte, cyc});
        if (rx0.frame_end) ge0.push_back(rx0.frame_error);
        if ((rx0.byte_valid && rx0.frame_end) || (rx0.byte_valid && !rx0.frame_active) ||
            (rx0.frame_end && rx0.frame_active)) viol0 = viol0 + 1;
        if (rx1.byte_valid) gb1.push_back('{rx1.received_byte, cyc});
        if (rx1.frame_end) ge1.push_back(rx1.frame_error);
        if ((rx1.byte_valid && rx1.frame_end) || (rx1.byte_valid && !rx1.frame_active) ||
            (rx1.frame_end && rx1.frame_active)) viol1 = viol1 + 1;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_frame();
        dq.delete();
        fb.delete();
        mk.delete();
    endtask

    task automatic push_dib(input logic [1:0] d, input logic crs, input logic er, input logic mark);
        dib_t t;
        t.d    = d;
        t.crs  = crs;
        t.er   = er;
        t.mark = mark;
        dq.push_back(t);
    endtask

    // tog: CRS_DV low on the first dibit of each nibble. er_dib: dibit carrying RXER.
    task automatic push_byte(input logic [7:0] b, input logic tog, input int er_dib, input logic is_frame);
        for (int i = 0; i < 4; i++) begin
            push_dib(b[2*i +: 2], !(tog && (i % 2 == 0)), i == er_dib, is_frame && (i == 3));
        end
        if (is_frame) fb.push_back(b);
    endtask

    task automatic std_preamble();
        for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0, -1, 1'b0);
        push_byte(8'hD5, 1'b0, -1, 1'b1);
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(posedge clk);
            #1;
            crs_dv = dq[i].crs;
            rxd    = dq[i].d;
            rx_er  = dq[i].er;
            if (dq[i].mark) mk.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            crs_dv = 1'b0;
            rxd    = 2'b00;
            rx_er  = 1'b0;
        end
    endtask

    task automatic sync_ptrs();
        rd[0] = gb0.size(); rd[1] = gb1.size();
        re[0] = ge0.size(); re[1] = ge1.size();
        vb[0] = viol0;      vb[1] = viol1;
    endtask

    // Expected: a valid frame yields the SFD plus its payload bytes (capped at
    // the size limit), each 3 cycles after its last dibit is driven, then one
    // frame_end whose error is RXER, a partial byte or oversize.
    task automatic verify_one(input string tag, input int k, input logic valid, input logic errf);
        ev_t  g[$];
        logic e[$];
        int   m, p, nexp, nb, ne, v;
        logic over;
        if (k == 0) begin g = gb0; e = ge0; m = BIG_MAX;   v = viol0; end
        else        begin g = gb1; e = ge1; m = SMALL_MAX; v = viol1; end
        p    = fb.size() - 1;
        over = valid && (p > m);
        nexp = !valid ? 0 : (over ? m + 1 : fb.size());
        nb   = g.size() - rd[k];
        chk($sformatf("%s/dut%0d/nbytes", tag, k), 64'(nb), 64'(nexp));
        for (int i = 0; i < nexp && i < nb; i++) begin
            chk($sformatf("%s/dut%0d/byte%0d", tag, k, i),
                64'({g[rd[k] + i].b, g[rd[k] + i].c}), 64'({fb[i], mk[i] + 32'd3}));
        end
        ne = e.size() - re[k];
        chk($sformatf("%s/dut%0d/nends", tag, k), 64'(ne), valid ? 64'd1 : 64'd0);
        if (valid && ne >= 1) begin
            chk($sformatf("%s/dut%0d/ferr", tag, k), 64'(e[re[k]]), 64'(errf || over));
        end
        chk($sformatf("%s/dut%0d/protocol", tag, k), 64'(v - vb[k]), 64'd0);
    endtask

    task automatic run_and_verify(input string tag, input logic valid, input logic errf);
        play(0, dq.size());
        idle(12);
        verify_one(tag, 0, valid, errf);
        verify_one(tag, 1, valid, errf);
        sync_ptrs();
    endtask

    task automatic random_frame(input string tag, input int len);
        new_frame();
        std_preamble();
        for (int i = 0; i < len; i++) push_byte(8'($urandom), 1'b0, -1, 1'b1);
        run_and_verify(tag, 1'b1, 1'b0);
    endtask

    int   len, extra, erb, cut;
    logic has_er;

    initial begin
        sync_ptrs();
        repeat (3) @(negedge clk);
        chk("reset/dut0", 64'({rx0.received_byte, rx0.byte_valid, rx0.frame_active, rx0.frame_end, rx0.frame_error}), 64'd0);
        chk("reset/dut1", 64'({rx1.received_byte, rx1.byte_valid, rx1.frame_active, rx1.frame_end, rx1.frame_error}), 64'd0);
        resetn = 1'b1;
        idle(4);

        new_frame();
        std_preamble();
        for (int b = 0; b < 60; b++) push_byte(8'(b), 1'b0, -1, 1'b1);
        run_and_verify("basic", 1'b1, 1'b0);

        new_frame();
        std_preamble();
        for (int b = 0; b < 60; b++) push_byte(8'(b), b >= 56, -1, 1'b1);
        run_and_verify("toggle", 1'b1, 1'b0);

        new_frame();
        std_preamble();
        for (int b = 0; b < 20; b++) push_byte(8'($urandom), 1'b0, -1, 1'b1);
        push_dib(2'($urandom), 1'b1, 1'b0, 1'b0);
        push_dib(2'($urandom), 1'b1, 1'b0, 1'b0);
        run_and_verify("trunc", 1'b1, 1'b1);

        new_frame();
        std_preamble();
        for (int b = 0; b < 30; b++) push_byte(8'($urandom), 1'b0, (b == 12) ? 1 : -1, 1'b1);
        run_and_verify("rxer", 1'b1, 1'b1);

        new_frame();
        for (int i = 0; i < 4; i++) push_dib(2'b01, 1'b1, 1'b0, 1'b0);
        push_dib(2'b11, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++) push_byte(8'($urandom), 1'b0, -1, 1'b1);
        run_and_verify("shortpre", 1'b0, 1'b0);
        random_frame("after_shortpre", 30);

        new_frame();
        push_dib(2'b10, 1'b1, 1'b0, 1'b0);
        std_preamble();
        for (int b = 0; b < 20; b++) push_byte(8'($urandom), 1'b0, -1, 1'b1);
        run_and_verify("falsecar", 1'b0, 1'b0);
        random_frame("after_falsecar", 30);

        random_frame("oversize70", 70);
        random_frame("after_oversize", 40);

        // Reset during the payload; the rest of the carrier holds only 00 dibits.
        new_frame();
        std_preamble();
        for (int b = 0; b < 10; b++) push_byte(8'($urandom), 1'b0, -1, 1'b1);
        for (int b = 0; b < 20; b++) push_byte(8'h00, 1'b0, -1, 1'b1);
        cut = 4 * 20;
        play(0, cut);
        resetn = 1'b0;
        #1;
        chk("midreset/dut0", 64'({rx0.byte_valid, rx0.frame_active, rx0.frame_end, rx0.frame_error}), 64'd0);
        chk("midreset/dut1", 64'({rx1.byte_valid, rx1.frame_active, rx1.frame_end, rx1.frame_error}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sync_ptrs();
        play(cut, dq.size());
        idle(12);
        verify_one("midreset_rest", 0, 1'b0, 1'b0);
        verify_one("midreset_rest", 1, 1'b0, 1'b0);
        sync_ptrs();
        random_frame("after_reset", 25);

        for (int f = 0; f < 4; f++) begin
            len    = $urandom_range(1, 80);
            extra  = $urandom_range(0, 3);
            erb    = $urandom_range(0, len - 1);
            has_er = ($urandom_range(0, 3) == 0);
            new_frame();
            std_preamble();
            for (int i = 0; i < len; i++) begin
                push_byte(8'($urandom), 1'($urandom_range(0, 1)), (has_er && i == erb) ? 2 : -1, 1'b1);
            end
            for (int j = 0; j < extra; j++) push_dib(2'($urandom), 1'b1, 1'b0, 1'b0);
            run_and_verify($sformatf("rnd%0d", f), 1'b1, has_er || (extra != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
